// File: rtl/pkt_order_checker.sv
// -----------------------------------------------------------------------------
// pkt_order_checker
//
// Avalon-ST sink that terminates the sorted-packet stream. For every packet it
// checks framing (SOP/EOP placement), that data words are non-decreasing, and
// that the word count and word sum match the expected values sampled on the
// SOP beat. It emits a one-cycle verdict pulse and keeps saturating counters.
//
// Optional build macro: PKT_ORDER_CHECKER_BACKPRESSURE_EN
//   When defined, snk_ready_o follows bit 0 of an 8-bit Fibonacci LFSR
//   (x^8+x^6+x^5+x^4+1, seed 8'hA5) that advances every cycle. When
//   undefined, snk_ready_o is constantly 1.
//
// Ports:
//   clk_i, arstn_i          clock, asynchronous active-low reset
//   snk_*                   Avalon-ST sink (data, sop, eop, valid, ready)
//   exp_len_i, exp_sum_i    expected length/sum, sampled on the SOP beat
//   pkt_done_o              one-cycle pulse when a verdict is ready
//   pkt_ok_o, err_*_o       verdict and error details of the last packet
//   pkt_len_o               words counted in the last packet
//   pkt_cnt_o, err_cnt_o    packets reported / packets reported with errors
//   stray_cnt_o             words discarded outside any packet
// -----------------------------------------------------------------------------
module pkt_order_checker #(
  parameter int DWIDTH      = 16,
  parameter int MAX_PKT_LEN = 32,
  parameter int CNT_WIDTH   = 16,
  localparam int LWIDTH     = $clog2(MAX_PKT_LEN + 1),
  localparam int SWIDTH     = DWIDTH + LWIDTH
) (
  input  logic                 clk_i,
  input  logic                 arstn_i,
  input  logic [DWIDTH-1:0]    snk_data_i,
  input  logic                 snk_startofpacket_i,
  input  logic                 snk_endofpacket_i,
  input  logic                 snk_valid_i,
  output logic                 snk_ready_o,
  input  logic [LWIDTH-1:0]    exp_len_i,
  input  logic [SWIDTH-1:0]    exp_sum_i,
  output logic                 pkt_done_o,
  output logic                 pkt_ok_o,
  output logic                 err_order_o,
  output logic                 err_frame_o,
  output logic                 err_len_o,
  output logic                 err_sum_o,
  output logic [LWIDTH-1:0]    pkt_len_o,
  output logic [CNT_WIDTH-1:0] pkt_cnt_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o,
  output logic [CNT_WIDTH-1:0] stray_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam logic [LWIDTH-1:0] MAX_LEN_L = LWIDTH'(MAX_PKT_LEN);

  // Saturating increment for the statistics counters.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (v == {CNT_WIDTH{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_WIDTH'(1);
    end
  endfunction

  state_e                state_q, state_d;
  logic [LWIDTH-1:0]     len_q, len_d;
  logic [SWIDTH-1:0]     sum_q, sum_d;
  logic [DWIDTH-1:0]     prev_q, prev_d;
  logic [LWIDTH-1:0]     exp_len_q, exp_len_d;
  logic [SWIDTH-1:0]     exp_sum_q, exp_sum_d;
  logic                  f_order_q, f_order_d;
  logic                  f_frame_q, f_frame_d;
  logic                  f_len_q, f_len_d;

  logic                  done_q, done_d;
  logic                  ok_q, ok_d;
  logic                  e_order_q, e_order_d;
  logic                  e_frame_q, e_frame_d;
  logic                  e_len_q, e_len_d;
  logic                  e_sum_q, e_sum_d;
  logic [LWIDTH-1:0]     plen_q, plen_d;
  logic [CNT_WIDTH-1:0]  pcnt_q, pcnt_d;
  logic [CNT_WIDTH-1:0]  ecnt_q, ecnt_d;
  logic [CNT_WIDTH-1:0]  scnt_q, scnt_d;

  logic                  ready_s;
  logic                  beat_s;
  logic                  finish_s;
  logic                  stray_s;
  logic                  ovf_s;
  logic                  v_len_s;
  logic                  v_sum_s;
  logic                  v_ok_s;

`ifdef PKT_ORDER_CHECKER_BACKPRESSURE_EN
  logic [7:0] lfsr_q, lfsr_d;

  // LFSR next state: taps 8,6,5,4 fed back into bit 0.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // LFSR register; the seed has bit 0 set so ready is high out of reset.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign ready_s = lfsr_q[0];
`else
  assign ready_s = 1'b1;
`endif

  assign snk_ready_o = ready_s;
  assign beat_s      = snk_valid_i & ready_s;

  // Packet FSM next state and working registers.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    sum_d     = sum_q;
    prev_d    = prev_q;
    exp_len_d = exp_len_q;
    exp_sum_d = exp_sum_q;
    f_order_d = f_order_q;
    f_frame_d = f_frame_q;
    f_len_d   = f_len_q;
    finish_s  = 1'b0;
    stray_s   = 1'b0;
    // The packet is full and this beat neither closes it nor reframes it.
    ovf_s     = (len_q == MAX_LEN_L) && !snk_endofpacket_i && !snk_startofpacket_i;

    case (state_q)
      S_IDLE: begin
        if (beat_s && snk_startofpacket_i) begin
          len_d     = LWIDTH'(1);
          sum_d     = SWIDTH'(snk_data_i);
          prev_d    = snk_data_i;
          exp_len_d = exp_len_i;
          exp_sum_d = exp_sum_i;
          f_order_d = 1'b0;
          f_frame_d = 1'b0;
          f_len_d   = 1'b0;
          if (snk_endofpacket_i) begin
            finish_s = 1'b1;
            state_d  = S_IDLE;
          end else begin
            state_d  = S_RECV;
          end
        end else if (beat_s) begin
          stray_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RECV: begin
        if (beat_s && ovf_s) begin
          f_len_d = 1'b1;
          state_d = S_DRAIN;
        end else if (beat_s) begin
          if (snk_data_i < prev_q) begin
            f_order_d = 1'b1;
          end else begin
            f_order_d = f_order_q;
          end
          len_d  = len_q + LWIDTH'(1);
          sum_d  = sum_q + SWIDTH'(snk_data_i);
          prev_d = snk_data_i;
          if (snk_startofpacket_i) begin
            f_frame_d = 1'b1;
          end else begin
            f_frame_d = f_frame_q;
          end
          if (snk_endofpacket_i) begin
            finish_s = 1'b1;
            state_d  = S_IDLE;
          end else if (snk_startofpacket_i) begin
            state_d  = S_DRAIN;
          end else begin
            state_d  = S_RECV;
          end
        end else begin
          state_d = S_RECV;
        end
      end

      S_DRAIN: begin
        if (beat_s && snk_endofpacket_i) begin
          finish_s = 1'b1;
          state_d  = S_IDLE;
        end else begin
          state_d  = S_DRAIN;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Verdict is formed from the post-beat values so it reflects the final word.
  always_comb begin
    v_len_s = f_len_d | (len_d != exp_len_d);
    v_sum_s = (sum_d != exp_sum_d);
    v_ok_s  = ~(f_order_d | f_frame_d | v_len_s | v_sum_s);
  end

  // Status outputs and counters next state.
  always_comb begin
    done_d    = finish_s;
    ok_d      = ok_q;
    e_order_d = e_order_q;
    e_frame_d = e_frame_q;
    e_len_d   = e_len_q;
    e_sum_d   = e_sum_q;
    plen_d    = plen_q;
    pcnt_d    = pcnt_q;
    ecnt_d    = ecnt_q;
    scnt_d    = scnt_q;
    if (finish_s) begin
      ok_d      = v_ok_s;
      e_order_d = f_order_d;
      e_frame_d = f_frame_d;
      e_len_d   = v_len_s;
      e_sum_d   = v_sum_s;
      plen_d    = len_d;
      pcnt_d    = sat_inc(pcnt_q);
      if (!v_ok_s) begin
        ecnt_d = sat_inc(ecnt_q);
      end else begin
        ecnt_d = ecnt_q;
      end
    end else begin
      done_d = 1'b0;
    end
    if (stray_s) begin
      scnt_d = sat_inc(scnt_q);
    end else begin
      scnt_d = scnt_q;
    end
  end

  // State, working and output registers; reset drops any partial packet.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      sum_q     <= '0;
      prev_q    <= '0;
      exp_len_q <= '0;
      exp_sum_q <= '0;
      f_order_q <= 1'b0;
      f_frame_q <= 1'b0;
      f_len_q   <= 1'b0;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      e_order_q <= 1'b0;
      e_frame_q <= 1'b0;
      e_len_q   <= 1'b0;
      e_sum_q   <= 1'b0;
      plen_q    <= '0;
      pcnt_q    <= '0;
      ecnt_q    <= '0;
      scnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      prev_q    <= prev_d;
      exp_len_q <= exp_len_d;
      exp_sum_q <= exp_sum_d;
      f_order_q <= f_order_d;
      f_frame_q <= f_frame_d;
      f_len_q   <= f_len_d;
      done_q    <= done_d;
      ok_q      <= ok_d;
      e_order_q <= e_order_d;
      e_frame_q <= e_frame_d;
      e_len_q   <= e_len_d;
      e_sum_q   <= e_sum_d;
      plen_q    <= plen_d;
      pcnt_q    <= pcnt_d;
      ecnt_q    <= ecnt_d;
      scnt_q    <= scnt_d;
    end
  end

  assign pkt_done_o  = done_q;
  assign pkt_ok_o    = ok_q;
  assign err_order_o = e_order_q;
  assign err_frame_o = e_frame_q;
  assign err_len_o   = e_len_q;
  assign err_sum_o   = e_sum_q;
  assign pkt_len_o   = plen_q;
  assign pkt_cnt_o   = pcnt_q;
  assign err_cnt_o   = ecnt_q;
  assign stray_cnt_o = scnt_q;

endmodule
